cycle_sequencer: RTL and testbench

- Timing generator for the CPU control unit. Produces the one-hot T-state (step) and M-cycle (count) vectors that every instruction microcode block decodes.
- Latches the fetched opcode into the instruction register and tracks the CB prefix.
- Implements HALT and stall.
- Sits directly upstream of the microcode blocks and consumes their OR-combined IR-fetch request.

---
 rtl/cycle_sequencer_if.sv | 49 ++++
 rtl/cycle_sequencer.sv | 118 +++++++++++
 tb/tb_cycle_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cycle_sequencer_if.sv
// Sequencer control/bus bundle shared with the microcode side.
// Master drives the request inputs, slave is the sequencer.
interface cycle_sequencer_if #(
  parameter int STEPS  = 4,
  parameter int CYCLES = 8
);
  logic              i_Enable;
  logic              i_Stall;
  logic              i_IR_Fetch;
  logic              i_Halt_Req;
  logic              i_Wake;
  logic [7:0]        i_Bus_Data;
  logic [STEPS-1:0]  o_Cycle_Step;
  logic [CYCLES-1:0] o_Cycle_Count;
  logic [7:0]        o_Instruction;
  logic              o_CB_Prefix;
  logic              o_Halted;
  logic              o_Overflow;

  modport master (
    output i_Enable,
    output i_Stall,
    output i_IR_Fetch,
    output i_Halt_Req,
    output i_Wake,
    output i_Bus_Data,
    input  o_Cycle_Step,
    input  o_Cycle_Count,
    input  o_Instruction,
    input  o_CB_Prefix,
    input  o_Halted,
    input  o_Overflow
  );

  modport slave (
    input  i_Enable,
    input  i_Stall,
    input  i_IR_Fetch,
    input  i_Halt_Req,
    input  i_Wake,
    input  i_Bus_Data,
    output o_Cycle_Step,
    output o_Cycle_Count,
    output o_Instruction,
    output o_CB_Prefix,
    output o_Halted,
    output o_Overflow
  );
endinterface

// File: rtl/cycle_sequencer.sv
// T-state / M-cycle timing generator with opcode latch,
// CB-prefix tracking, HALT and stall.
module cycle_sequencer #(
  parameter int         STEPS        = 4,
  parameter int         CYCLES       = 8,
  parameter logic [7:0] RESET_OPCODE = 8'h00
) (
  input  logic        i_Clk,
  input  logic        i_Reset_n,
  cycle_sequencer_if.slave bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef struct packed {
    state_t            st;
    logic [STEPS-1:0]  step;
    logic [CYCLES-1:0] count;
    logic [7:0]        ir;
    logic              cb;
    logic              ovf;
  } seq_t;

  localparam logic [STEPS-1:0]  STEP_ONE = STEPS'(1);
  localparam logic [CYCLES-1:0] CNT_ONE  = CYCLES'(1);
  localparam logic [7:0]        CB_OP    = 8'hCB;

  seq_t q;
  seq_t d;

  logic adv;
  logic mc_end;
  logic cnt_last;

  assign adv      = bus.i_Enable & ~bus.i_Stall;
  assign mc_end   = q.step[STEPS-1];
  assign cnt_last = q.count[CYCLES-1];

  // State register; everything the outputs show lives here.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      q.st    <= RUN;
      q.step  <= STEP_ONE;
      q.count <= CNT_ONE;
      q.ir    <= RESET_OPCODE;
      q.cb    <= 1'b0;
      q.ovf   <= 1'b0;
    end else begin
      q <= d;
    end
  end

  // Next-state: step rotation, M-cycle advance, fetch, halt, wake.
  always_comb begin
    d = q;
    if (adv) begin
      unique case (q.st)
        RUN: begin
          d.step = {q.step[STEPS-2:0], q.step[STEPS-1]};
          unique case (1'b1)
            (mc_end && bus.i_IR_Fetch): begin
              d.count = CNT_ONE;
              d.ir    = bus.i_Bus_Data;
              d.cb    = (q.ir == CB_OP) && !q.cb;
              if (bus.i_Halt_Req) begin
                d.st   = HALT;
                d.step = STEP_ONE;
              end
            end
            (mc_end && !bus.i_IR_Fetch && cnt_last): begin
              d.count = CNT_ONE;
              d.ovf   = 1'b1;
            end
            (mc_end && !bus.i_IR_Fetch && !cnt_last): begin
              d.count = {q.count[CYCLES-2:0], 1'b0};
            end
            default: begin
              d.count = q.count;
            end
          endcase
        end
        HALT: begin
          d.step  = STEP_ONE;
          d.count = CNT_ONE;
          if (bus.i_Wake) begin
            d.st = RUN;
          end
        end
        default: begin
          d.st = RUN;
        end
      endcase
    end
  end

  // Outputs are straight register taps.
  assign bus.o_Cycle_Step  = q.step;
  assign bus.o_Cycle_Count = q.count;
  assign bus.o_Instruction = q.ir;
  assign bus.o_CB_Prefix   = q.cb;
  assign bus.o_Halted      = (q.st == HALT);
  assign bus.o_Overflow    = q.ovf;

  // Both timing vectors must stay exactly one-hot.
  a_step_onehot : assert property (
    @(posedge i_Clk) disable iff (!i_Reset_n)
    $onehot(q.step)
  );

  a_count_onehot : assert property (
    @(posedge i_Clk) disable iff (!i_Reset_n)
    $onehot(q.count)
  );

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer against a
// T/M index model driven by directed and random stimulus.
module tb_cycle_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cycle_sequencer_if #(.STEPS(4), .CYCLES(8)) bus ();

  cycle_sequencer #(
    .STEPS(4),
    .CYCLES(8),
    .RESET_OPCODE(8'h00)
  ) dut (
    .i_Clk    (clk),
    .i_Reset_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: T-state index, M-cycle index, flags
  int         m_t;
  int         m_m;
  logic [7:0] m_ir;
  logic       m_cb;
  logic       m_halt;
  logic       m_ovf;

  function automatic logic [3:0] exp_step();
    return 4'(1 << m_t);
  endfunction

  function automatic logic [7:0] exp_cnt();
    return 8'(1 << m_m);
  endfunction

  task automatic model_reset();
    m_t = 0; m_m = 0; m_ir = 8'h00;
    m_cb = 0; m_halt = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    if (!(bus.i_Enable && !bus.i_Stall)) return;
    if (m_halt) begin
      if (bus.i_Wake) m_halt = 0;
      return;
    end
    if (m_t != 3) begin
      m_t = m_t + 1;
      return;
    end
    m_t = 0;
    if (bus.i_IR_Fetch) begin
      m_cb = (m_ir == 8'hCB) && !m_cb;
      m_ir = bus.i_Bus_Data;
      m_m = 0;
      if (bus.i_Halt_Req) m_halt = 1;
    end else if (m_m == 7) begin
      m_ovf = 1;
      m_m = 0;
    end else begin
      m_m = m_m + 1;
    end
  endtask

  task automatic idle_inputs();
    bus.i_Enable = 1; bus.i_Stall = 0;
    bus.i_IR_Fetch = 0; bus.i_Halt_Req = 0;
    bus.i_Wake = 0; bus.i_Bus_Data = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // run to and through the next M-cycle end with a fetch
  task automatic do_fetch(input logic [7:0] op, input logic hreq);
    bus.i_IR_Fetch = 1; bus.i_Bus_Data = op;
    bus.i_Halt_Req = hreq;
    for (int i = 0; i < 4; i++) begin
      if (m_t == 3) begin
        tick();
        break;
      end
      tick();
    end
    bus.i_IR_Fetch = 0; bus.i_Halt_Req = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    apply_reset();
    checks++; if (bus.o_Cycle_Step !== 4'b0001) begin errors++; $display("FAIL rst_step got=%b exp=0001", bus.o_Cycle_Step); end
    checks++; if (bus.o_Cycle_Count !== 8'h01) begin errors++; $display("FAIL rst_count got=%h exp=01", bus.o_Cycle_Count); end
    checks++; if (bus.o_Instruction !== 8'h00) begin errors++; $display("FAIL rst_ir got=%h exp=00", bus.o_Instruction); end
    checks++; if ({bus.o_CB_Prefix, bus.o_Halted, bus.o_Overflow} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {bus.o_CB_Prefix, bus.o_Halted, bus.o_Overflow}); end
  endtask

  task automatic test_step_sequence();
    logic [3:0] seq [4];
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bus.o_Cycle_Step !== seq[i % 4]) begin errors++; $display("FAIL seq_step i=%0d got=%b exp=%b", i, bus.o_Cycle_Step, seq[i % 4]); end
      if (i == 3) begin
        checks++; if (bus.o_Cycle_Count !== 8'h02) begin errors++; $display("FAIL seq_cnt4 got=%h exp=02", bus.o_Cycle_Count); end
      end
    end
    checks++; if (bus.o_Cycle_Count !== 8'h04) begin errors++; $display("FAIL seq_cnt8 got=%h exp=04", bus.o_Cycle_Count); end
  endtask

  task automatic test_fetch();
    do_fetch(8'h18, 1'b0);
    checks++; if (bus.o_Instruction !== 8'h18) begin errors++; $display("FAIL fetch_ir got=%h exp=18", bus.o_Instruction); end
    checks++; if (bus.o_Cycle_Count !== 8'h01) begin errors++; $display("FAIL fetch_cnt got=%h exp=01", bus.o_Cycle_Count); end
    checks++; if (bus.o_Cycle_Step !== 4'b0001) begin errors++; $display("FAIL fetch_step got=%b exp=0001", bus.o_Cycle_Step); end
  endtask

  task automatic test_cb_prefix();
    logic [7:0] ops [5];
    logic       cbx [5];
    ops = '{8'hCB, 8'h7C, 8'hCB, 8'hCB, 8'h00};
    cbx = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      do_fetch(ops[i], 1'b0);
      checks++; if (bus.o_CB_Prefix !== cbx[i] || bus.o_Instruction !== ops[i]) begin errors++; $display("FAIL cb_seq i=%0d got=%b/%h exp=%b/%h", i, bus.o_CB_Prefix, bus.o_Instruction, cbx[i], ops[i]); end
    end
  endtask

  task automatic test_halt();
    do_fetch(8'h76, 1'b1);
    checks++; if (bus.o_Halted !== 1'b1) begin errors++; $display("FAIL halt_enter got=%b exp=1", bus.o_Halted); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (bus.o_Cycle_Step !== 4'b0001 || bus.o_Cycle_Count !== 8'h01 || bus.o_Halted !== 1'b1) begin errors++; $display("FAIL halt_hold i=%0d got=%b/%h/%b exp=0001/01/1", i, bus.o_Cycle_Step, bus.o_Cycle_Count, bus.o_Halted); end
    end
    bus.i_Wake = 1;
    tick();
    bus.i_Wake = 0;
    checks++; if (bus.o_Halted !== 1'b0 || bus.o_Cycle_Step !== 4'b0001) begin errors++; $display("FAIL halt_wake got=%b/%b exp=0/0001", bus.o_Halted, bus.o_Cycle_Step); end
    checks++; if (bus.o_Instruction !== 8'h76) begin errors++; $display("FAIL halt_ir got=%h exp=76", bus.o_Instruction); end
    tick();
    checks++; if (bus.o_Cycle_Step !== 4'b0010) begin errors++; $display("FAIL halt_resume got=%b exp=0010", bus.o_Cycle_Step); end
  endtask

  task automatic test_halt_wake_same();
    bus.i_Wake = 1;
    do_fetch(8'h76, 1'b1);
    checks++; if (bus.o_Halted !== 1'b1) begin errors++; $display("FAIL hw_same got=%b exp=1", bus.o_Halted); end
    tick();
    bus.i_Wake = 0;
    checks++; if (bus.o_Halted !== 1'b0 || bus.o_Cycle_Step !== 4'b0001) begin errors++; $display("FAIL hw_exit got=%b/%b exp=0/0001", bus.o_Halted, bus.o_Cycle_Step); end
    tick();
  endtask

  task automatic test_stall();
    logic [3:0] s0;
    logic [7:0] c0;
    tick();
    checks++; if (bus.o_Cycle_Step !== 4'b0100) begin errors++; $display("FAIL stall_pre got=%b exp=0100", bus.o_Cycle_Step); end
    s0 = bus.o_Cycle_Step; c0 = bus.o_Cycle_Count;
    bus.i_Stall = 1; bus.i_IR_Fetch = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.o_Cycle_Step !== exp_step() || bus.o_Cycle_Count !== exp_cnt()) begin errors++; $display("FAIL stall_hold i=%0d got=%b/%h exp=%b/%h", i, bus.o_Cycle_Step, bus.o_Cycle_Count, exp_step(), exp_cnt()); end
    end
    checks++; if (bus.o_Cycle_Step !== s0 || bus.o_Cycle_Count !== c0) begin errors++; $display("FAIL stall_same got=%b/%h exp=%b/%h", bus.o_Cycle_Step, bus.o_Cycle_Count, s0, c0); end
    bus.i_Stall = 0; bus.i_IR_Fetch = 0;
    bus.i_Enable = 0;
    tick();
    checks++; if (bus.o_Cycle_Step !== 4'b0100) begin errors++; $display("FAIL en_hold got=%b exp=0100", bus.o_Cycle_Step); end
    bus.i_Enable = 1;
    tick();
    checks++; if (bus.o_Cycle_Step !== 4'b1000) begin errors++; $display("FAIL stall_release got=%b exp=1000", bus.o_Cycle_Step); end
  endtask

  task automatic test_overflow();
    idle_inputs();
    apply_reset();
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 31) begin
        checks++; if (bus.o_Overflow !== 1'b0 || bus.o_Cycle_Count !== 8'h80) begin errors++; $display("FAIL ovf_early got=%b/%h exp=0/80", bus.o_Overflow, bus.o_Cycle_Count); end
      end
    end
    checks++; if (bus.o_Overflow !== 1'b1 || bus.o_Cycle_Count !== 8'h01) begin errors++; $display("FAIL ovf_set got=%b/%h exp=1/01", bus.o_Overflow, bus.o_Cycle_Count); end
    do_fetch(8'h3E, 1'b0);
    checks++; if (bus.o_Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.o_Overflow); end
    tick();
    @(posedge clk);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    checks++; if (bus.o_Overflow !== 1'b0 || bus.o_Cycle_Step !== 4'b0001 || bus.o_Cycle_Count !== 8'h01 || bus.o_Instruction !== 8'h00) begin errors++; $display("FAIL async_rst got=%b/%b/%h/%h exp=0/0001/01/00", bus.o_Overflow, bus.o_Cycle_Step, bus.o_Cycle_Count, bus.o_Instruction); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    int errs0;
    errs0 = errors;
    for (int i = 0; i < 3000; i++) begin
      bus.i_Enable   = ($urandom_range(0, 9) != 0);
      bus.i_Stall    = ($urandom_range(0, 7) == 0);
      bus.i_IR_Fetch = ($urandom_range(0, 5) == 0);
      bus.i_Halt_Req = ($urandom_range(0, 9) == 0);
      bus.i_Wake     = ($urandom_range(0, 6) == 0);
      bus.i_Bus_Data = ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom);
      tick();
      checks++;
      if (bus.o_Cycle_Step !== exp_step() || bus.o_Cycle_Count !== exp_cnt() || bus.o_Instruction !== m_ir || bus.o_CB_Prefix !== m_cb || bus.o_Halted !== m_halt || bus.o_Overflow !== m_ovf) begin
        errors++;
        if (errors - errs0 <= 10)
          $display("FAIL rand i=%0d got=%b/%h/%h/%b%b%b exp=%b/%h/%h/%b%b%b", i, bus.o_Cycle_Step, bus.o_Cycle_Count, bus.o_Instruction, bus.o_CB_Prefix, bus.o_Halted, bus.o_Overflow, exp_step(), exp_cnt(), m_ir, m_cb, m_halt, m_ovf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    idle_inputs();
    test_reset();
    test_step_sequence();
    test_fetch();
    test_cb_prefix();
    test_halt();
    test_halt_wake_same();
    test_stall();
    test_overflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
